// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_state_e;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam int unsigned MIN_BAUD_DIV = 4;

    // Wide enough for a bit index up to DATA_BITS-1 with DATA_BITS <= 9
    localparam int unsigned BIT_IDX_W = 4;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop RX synchroniser plus an edge-detect flop; all flops reset to the idle level 1.
module uart_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_rx,
    output logic o_level,
    output logic o_fall
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
            r_s3 <= 1'b1;
        end else begin
            r_s1 <= i_rx;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_level = r_s2;
    assign o_fall  = r_s3 & ~r_s2;

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: DATA_BITS data, runtime parity, 1/2 stop bits, error reporting.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around mid-bit.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned DIV_W     = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_rx,
    input  logic [DIV_W-1:0]     i_baud_div,
    input  logic [1:0]           i_parity_mode,
    input  logic                 i_two_stop,
    input  logic                 i_clr_rdy,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_rdy,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_overrun
);

    localparam logic [BIT_IDX_W-1:0] LAST_IDX = BIT_IDX_W'(DATA_BITS - 1);

    uart_state_e r_state;
    uart_state_e w_state_d;

    logic                 w_level;
    logic                 w_fall;
    logic                 w_tick;
    logic                 w_bit;

    logic [DIV_W-1:0]     r_cnt;
    logic [DIV_W-1:0]     r_div;
    logic [1:0]           r_par_mode;
    logic                 r_two_stop;
    logic [BIT_IDX_W-1:0] r_bit_idx;
    logic                 r_stop_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_err;
    logic                 r_frm_err;

    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rdy;
    logic                 r_parity_err;
    logic                 r_frame_err;
    logic                 r_overrun;

    logic                 w_par_en;
    logic                 w_last_data;
    logic                 w_last_stop;
    logic                 w_start;
    logic                 w_shift;
    logic                 w_par_chk;
    logic                 w_stop_smp;
    logic                 w_set_rdy;

    uart_sync u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_rx    (i_rx),
        .o_level (w_level),
        .o_fall  (w_fall)
    );

`ifdef UART_RX_MAJORITY_EN
    logic r_smp_a;
    logic r_smp_b;
    logic r_pend;

    // Samples at count 1 and 0; the third is the live level one cycle after reload
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || r_state == StIdle) begin
            r_smp_a <= 1'b1;
            r_smp_b <= 1'b1;
            r_pend  <= 1'b0;
        end else begin
            r_pend <= (r_cnt == '0);
            if (r_cnt == DIV_W'(1)) r_smp_a <= w_level;
            if (r_cnt == '0)        r_smp_b <= w_level;
        end
    end

    assign w_tick = r_pend;
    assign w_bit  = maj3(r_smp_a, r_smp_b, w_level);
`else
    assign w_tick = (r_cnt == '0);
    assign w_bit  = w_level;
`endif

    assign w_par_en    = (r_par_mode == PAR_EVEN) || (r_par_mode == PAR_ODD);
    assign w_last_data = (r_bit_idx == LAST_IDX);
    assign w_last_stop = r_stop_idx || !r_two_stop;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle:   if (w_fall) w_state_d = StStart;
            StStart:  if (w_tick) w_state_d = w_bit ? StIdle : StData;
            StData:   if (w_tick && w_last_data) w_state_d = w_par_en ? StParity : StStop;
            StParity: if (w_tick) w_state_d = StStop;
            StStop:   if (w_tick && w_last_stop) w_state_d = StIdle;
            default:  w_state_d = StIdle;
        endcase
    end

    always_comb begin
        w_start    = 1'b0;
        w_shift    = 1'b0;
        w_par_chk  = 1'b0;
        w_stop_smp = 1'b0;
        w_set_rdy  = 1'b0;
        case (r_state)
            StIdle:   w_start   = w_fall;
            StData:   w_shift   = w_tick;
            StParity: w_par_chk = w_tick;
            StStop: begin
                w_stop_smp = w_tick;
                w_set_rdy  = w_tick && w_last_stop;
            end
            default: ;
        endcase
    end

    // Frame configuration is captured at the start edge and held for the whole frame
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt      <= '0;
            r_div      <= '0;
            r_par_mode <= PAR_NONE;
            r_two_stop <= 1'b0;
        end else if (r_state == StIdle) begin
            if (w_start) begin
                r_cnt      <= i_baud_div >> 1;
                r_div      <= i_baud_div;
                r_par_mode <= i_parity_mode;
                r_two_stop <= i_two_stop;
            end
        end else if (r_cnt == '0) begin
            r_cnt <= r_div - DIV_W'(1);
        end else begin
            r_cnt <= r_cnt - DIV_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_par_err  <= 1'b0;
            r_frm_err  <= 1'b0;
        end else begin
            if (w_start) begin
                r_bit_idx  <= '0;
                r_stop_idx <= 1'b0;
                r_par_err  <= 1'b0;
                r_frm_err  <= 1'b0;
            end
            if (w_shift) begin
                r_shift   <= {w_bit, r_shift[DATA_BITS-1:1]};
                r_bit_idx <= r_bit_idx + BIT_IDX_W'(1);
            end
            if (w_par_chk) begin
                r_par_err <= (^r_shift) ^ w_bit ^ (r_par_mode == PAR_ODD);
            end
            if (w_stop_smp) begin
                r_stop_idx <= 1'b1;
                if (!w_bit) r_frm_err <= 1'b1;
            end
        end
    end

    // Completion takes priority over a coincident clr_rdy
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rx_data    <= '0;
            r_rdy        <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else if (w_set_rdy) begin
            r_rx_data    <= r_shift;
            r_rdy        <= 1'b1;
            r_parity_err <= r_par_err;
            r_frame_err  <= r_frm_err | ~w_bit;
            r_overrun    <= r_rdy & ~i_clr_rdy;
        end else if (i_clr_rdy) begin
            r_rdy     <= 1'b0;
            r_overrun <= 1'b0;
        end
    end

    assign o_rx_data    = r_rx_data;
    assign o_rdy        = r_rdy;
    assign o_parity_err = r_parity_err;
    assign o_frame_err  = r_frame_err;
    assign o_overrun    = r_overrun;

endmodule
